lock_session_ctrl: RTL
======================

Name: lock_session_ctrl

Overview:
- Session controller placed in front of the combination-lock core (5-9-0-0-6-0 sequence checker with S/P/F result display).
- Forwards keypad digits to the core as single-cycle insere pulses and watches the core's result.
- Owns the session lifecycle: resets the core after each result or after an inactivity timeout, counts consecutive failures, and enforces a lockout period that grows on repeated lockouts.

Parameters:
HOLD_CYCLES, 8, cycles the result stays latched before the core is reset
TIMEOUT_CYCLES, 32, idle cycles allowed between digits while in ENTRY
MAX_FAILS, 3, consecutive F results that trigger a lockout
LOCKOUT_BASE, 16, lockout length at level 0 (cycles)
CNT_W, 8, width of the internal timers; must hold LOCKOUT_BASE<<3

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high
key_valid  in  1  one-cycle strobe: new digit on key_in
key_in  in  4  digit value 0-9
res_valid  in  1  one-cycle strobe from lock core: result available
res_code  in  2  0=none, 1=S (full success), 2=P (partial success), 3=F (fail)
lock_insere  out  1  registered insere pulse to core
lock_entrada  out  4  registered digit to core
lock_reset  out  1  registered reset to core
unlocked  out  1  high in SHOW when latched result is S or P
locked_out  out  1  high throughout LOCKOUT
fail_count  out  2  consecutive-F counter
timeout_pulse  out  1  one-cycle pulse on inactivity abort
key_drop  out  1  one-cycle pulse when a key_valid is ignored

Behaviour:
- Reset (sync, high): state=IDLE; lock_reset=1 during reset and for the first cycle after reset deasserts. All other outputs 0, including lock_entrada=0. fail_count=0; lockout level=0; timers=0.
- Forwarding: an accepted key_valid at cycle N gives lock_insere=1 and lock_entrada=key_in at cycle N+1, for exactly 1 cycle. lock_entrada holds its last value otherwise.
- IDLE: key_valid -> forward the digit, load the inactivity timer with TIMEOUT_CYCLES, go to ENTRY. res_valid is ignored.
- ENTRY:
  - Each key_valid is forwarded and reloads the timer.
  - With no key, the timer decrements.
  - When the timer reaches 0: pulse lock_reset and timeout_pulse for 1 cycle, go to IDLE. fail_count is unchanged.
  - res_valid with res_code!=0: latch res_code, load the hold timer with HOLD_CYCLES, go to SHOW.
  - res_valid and key_valid in the same cycle: the result wins, the key is not forwarded, and key_drop pulses.
  - res_valid with res_code=0 is ignored.
- SHOW:
  - unlocked = (latched code is S or P).
  - Counter updates on entry to SHOW:
    - S: fail_count=0 and lockout level=0.
    - P: fail_count=0; level unchanged.
    - F: fail_count+1, saturating at 3.
  - Every key_valid is dropped (key_drop pulses).
  - The hold timer counts down. At 0: pulse lock_reset for 1 cycle and clear unlocked. Then:
    - if fail_count>=MAX_FAILS: load the lockout timer with LOCKOUT_BASE<<level and go to LOCKOUT;
    - else go to IDLE.
- LOCKOUT:
  - locked_out=1; keys are dropped; res_valid is ignored.
  - The timer counts down. At 0: fail_count=0, level=min(level+1,3), locked_out=0, go to IDLE.
- Reset mid-operation (any state): immediate return to the reset values above. Any in-flight insere pulse is cancelled.
- Timers are CNT_W bits, unsigned, loaded with the full value. A timer that loads value V causes the exit V cycles after the load.

Optional Feature:
ADMIN_OVERRIDE_EN
- Defined:
  - Adds input port admin_clear (1 bit).
  - In LOCKOUT, admin_clear aborts the lockout next cycle: timer=0, fail_count=0, level=0, locked_out=0, state=IDLE.
  - In any other state, admin_clear clears fail_count and level only.
- Not defined: the port is absent and lockout can only end by timer expiry or reset.

Test Plan:
- Reset, keys 5,9,0,0,6,0 one every 10 cycles, core returns res_code=1 -> six 1-cycle lock_insere pulses each one cycle after key_valid, with lock_entrada matching the key. Then unlocked=1 for 8 cycles, then one lock_reset pulse, state IDLE, fail_count=0.
- Key 5, then no input for 32 cycles -> timeout_pulse and lock_reset at the 32nd idle cycle; next key 9 is forwarded as a fresh session.
- Three sessions each ending res_code=3 -> fail_count 1,2,3. After the third hold, locked_out=1 for 16 cycles; keys pressed meanwhile give key_drop with no lock_insere. Afterwards fail_count=0.
- Repeat the three F sessions twice more -> second lockout lasts 32 cycles, third 64. Then an S result followed by three Fs gives 16 cycles again.
- In ENTRY, res_valid(code=2) and key_valid in the same cycle -> no lock_insere, key_drop=1, unlocked=1, fail_count=0.
- With ADMIN_OVERRIDE_EN: admin_clear at cycle 5 of a lockout -> locked_out=0 next cycle, level=0, fail_count=0.

Source files
------------

// File: rtl/lock_session_ctrl.sv
// lock_session_ctrl: session front-end for the 5-9-0-0-6-0 combination-lock core.
// Optional feature: define ADMIN_OVERRIDE_EN to add the admin_clear input.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | no session open, waiting for the first digit
//   ENTRY   | digits being forwarded, inactivity timer running
//   SHOW    | result latched and displayed, hold timer running
//   LOCKOUT | too many consecutive fails, keys refused until timer expires

module lock_session_ctrl #(
    parameter int HOLD_CYCLES    = 8,
    parameter int TIMEOUT_CYCLES = 32,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_BASE   = 16,
    parameter int CNT_W          = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_in,
    input  logic       res_valid,
    input  logic [1:0] res_code,
`ifdef ADMIN_OVERRIDE_EN
    input  logic       admin_clear,
`endif
    output logic       lock_insere,
    output logic [3:0] lock_entrada,
    output logic       lock_reset,
    output logic       unlocked,
    output logic       locked_out,
    output logic [1:0] fail_count,
    output logic       timeout_pulse,
    output logic       key_drop
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ENTRY   = 2'd1,
        SHOW    = 2'd2,
        LOCKOUT = 2'd3
    } state_t;

    localparam logic [1:0]       CODE_NONE = 2'd0;
    localparam logic [1:0]       CODE_S    = 2'd1;
    localparam logic [1:0]       CODE_P    = 2'd2;
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    state_t           state, state_d;
    logic [CNT_W-1:0] timer, timer_d;
    logic [1:0]       code, code_d;
    logic [1:0]       fail_q, fail_d;
    logic [1:0]       level, level_d;
    logic             insere_q, insere_d;
    logic [3:0]       entrada_q, entrada_d;
    logic             lreset_q, lreset_d;
    logic             timeout_q, timeout_d;
    logic             drop_q, drop_d;
    logic             admin_req;
    logic             fail_limit;
    logic             timer_last;

`ifdef ADMIN_OVERRIDE_EN
    assign admin_req = admin_clear;
`else
    assign admin_req = 1'b0;
`endif

    assign fail_limit = ({30'd0, fail_q} >= 32'(MAX_FAILS));
    // Terminal count: the cycle that would bring the timer to zero is the exit cycle.
    assign timer_last = (timer <= ONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            timer     <= '0;
            code      <= '0;
            fail_q    <= '0;
            level     <= '0;
            insere_q  <= 1'b0;
            entrada_q <= '0;
            lreset_q  <= 1'b1;
            timeout_q <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            state     <= state_d;
            timer     <= timer_d;
            code      <= code_d;
            fail_q    <= fail_d;
            level     <= level_d;
            insere_q  <= insere_d;
            entrada_q <= entrada_d;
            lreset_q  <= lreset_d;
            timeout_q <= timeout_d;
            drop_q    <= drop_d;
        end
    end

    always_comb begin
        state_d   = state;
        timer_d   = timer;
        code_d    = code;
        fail_d    = fail_q;
        level_d   = level;
        insere_d  = 1'b0;
        entrada_d = entrada_q;
        lreset_d  = 1'b0;
        timeout_d = 1'b0;
        drop_d    = 1'b0;

        case (state)
            IDLE: begin
                if (key_valid) begin
                    insere_d  = 1'b1;
                    entrada_d = key_in;
                    timer_d   = CNT_W'(TIMEOUT_CYCLES);
                    state_d   = ENTRY;
                end
            end
            ENTRY: begin
                // A result takes priority over a digit arriving in the same cycle.
                if (res_valid && (res_code != CODE_NONE)) begin
                    code_d  = res_code;
                    timer_d = CNT_W'(HOLD_CYCLES);
                    state_d = SHOW;
                    drop_d  = key_valid;
                    if (res_code == CODE_S) begin
                        fail_d  = 2'd0;
                        level_d = 2'd0;
                    end else if (res_code == CODE_P) begin
                        fail_d = 2'd0;
                    end else if (fail_q != 2'd3) begin
                        fail_d = fail_q + 2'd1;
                    end
                end else if (key_valid) begin
                    insere_d  = 1'b1;
                    entrada_d = key_in;
                    timer_d   = CNT_W'(TIMEOUT_CYCLES);
                end else if (timer_last) begin
                    timer_d   = '0;
                    lreset_d  = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    timer_d = timer - ONE;
                end
            end
            SHOW: begin
                drop_d = key_valid;
                if (timer_last) begin
                    lreset_d = 1'b1;
                    if (fail_limit) begin
                        timer_d = CNT_W'(LOCKOUT_BASE) << level;
                        state_d = LOCKOUT;
                    end else begin
                        timer_d = '0;
                        state_d = IDLE;
                    end
                end else begin
                    timer_d = timer - ONE;
                end
            end
            LOCKOUT: begin
                drop_d = key_valid;
                if (timer_last) begin
                    timer_d = '0;
                    fail_d  = 2'd0;
                    level_d = (level == 2'd3) ? 2'd3 : level + 2'd1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer - ONE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (admin_req) begin
            fail_d  = 2'd0;
            level_d = 2'd0;
            if (state == LOCKOUT) begin
                timer_d = '0;
                state_d = IDLE;
            end
        end
    end

    assign lock_insere   = insere_q;
    assign lock_entrada  = entrada_q;
    assign lock_reset    = lreset_q;
    assign unlocked      = (state == SHOW) && ((code == CODE_S) || (code == CODE_P));
    assign locked_out    = (state == LOCKOUT);
    assign fail_count    = fail_q;
    assign timeout_pulse = timeout_q;
    assign key_drop      = drop_q;

endmodule
